// File: rtl/gf180mcu_fd_sc_mcu7t5v0__buf_leg_seq_pkg.sv
// Shared types and helpers for the buffer-leg enable sequencer.
package gf180mcu_fd_sc_mcu7t5v0__buf_leg_seq_pkg;

  localparam int unsigned MAX_LEG = 32;
  localparam int unsigned MAX_LW  = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2
  } state_e;

  // Thermometer code: bit i set when i < lvl, limited to the n physical legs.
  function automatic logic [MAX_LEG-1:0] therm(input logic [MAX_LW-1:0] lvl,
                                               input int unsigned n);
    logic [MAX_LEG-1:0] t;
    for (int unsigned i = 0; i < MAX_LEG; i++) begin
      t[i] = (i < 32'(lvl)) && (i < n);
    end
    return t;
  endfunction

  // Requests above the leg count saturate to the leg count.
  function automatic logic [MAX_LW-1:0] sat_tgt(input logic [MAX_LW-1:0] tgt,
                                                input int unsigned n);
    return (32'(tgt) > n) ? MAX_LW'(n) : tgt;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__buf_leg_seq_tmr.sv
// Loadable down-counter that stops at zero; shared by step and settle intervals.
module gf180mcu_fd_sc_mcu7t5v0__buf_leg_seq_tmr #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_c_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__buf_leg_seq.sv
// Steps the enables of a parallel buffer-leg array one leg at a time toward a
// requested drive level, then settles and pulses ACK.
module gf180mcu_fd_sc_mcu7t5v0__buf_leg_seq
  import gf180mcu_fd_sc_mcu7t5v0__buf_leg_seq_pkg::*;
#(
  parameter int unsigned NLEG       = 8,
  parameter int unsigned STEP_CYC   = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned LW         = $clog2(NLEG + 1)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ,
  input  logic [LW-1:0]   TGT,
  output logic            ACK,
  output logic            BUSY,
  output logic [LW-1:0]   LVL,
  output logic [NLEG-1:0] EN
);

  localparam int unsigned TMR_MAX = (STEP_CYC > SETTLE_CYC) ? STEP_CYC : SETTLE_CYC;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);

  state_e          state_q, state_d;
  logic [LW-1:0]   tgt_q, tgt_d;
  logic [LW-1:0]   lvl_q, lvl_d;
  logic [NLEG-1:0] en_q, en_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;

  logic [LW-1:0]   tgt_sat;
  logic [LW-1:0]   lvl_step;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_zero;

  assign tgt_sat  = LW'(sat_tgt(MAX_LW'(TGT), NLEG));
  assign lvl_step = (tgt_q > lvl_q) ? lvl_q + LW'(1) : lvl_q - LW'(1);

  gf180mcu_fd_sc_mcu7t5v0__buf_leg_seq_tmr #(
    .W (TW)
  ) u_tmr (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_c_o   (tmr_zero)
  );

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      lvl_q   <= '0;
      en_q    <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      lvl_q   <= lvl_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state; requests are only accepted from IDLE.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    case (state_q)
      IDLE: begin
        if (REQ) begin
          tgt_d = tgt_sat;
          if (tgt_sat != lvl_q) state_d = RAMP;
        end
      end
      RAMP: begin
        if (tmr_zero && (lvl_step == tgt_q)) state_d = SETTLE;
      end
      SETTLE: begin
        if (tmr_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values and timer control.
  always_comb begin
    lvl_d    = lvl_q;
    ack_d    = 1'b0;
    busy_d   = busy_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (REQ) begin
          if (tgt_sat == lvl_q) begin
            ack_d = 1'b1;
          end else begin
            busy_d   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = TW'(STEP_CYC - 1);
          end
        end
      end
      RAMP: begin
        if (tmr_zero) begin
          lvl_d    = lvl_step;
          tmr_load = 1'b1;
          tmr_val  = (lvl_step == tgt_q) ? TW'(SETTLE_CYC - 1) : TW'(STEP_CYC - 1);
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          busy_d = 1'b0;
          ack_d  = 1'b1;
        end
      end
      default: busy_d = 1'b0;
    endcase
    en_d = NLEG'(therm(MAX_LW'(lvl_d), NLEG));
  end

  assign ACK  = ack_q;
  assign BUSY = busy_q;
  assign LVL  = lvl_q;
  assign EN   = en_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__buf_leg_seq.sv
// Directed plus randomized bench for the buffer-leg sequencer against a
// timeline model of each accepted request.
module tb_gf180mcu_fd_sc_mcu7t5v0__buf_leg_seq;

  localparam int unsigned NLEG   = 8;
  localparam int unsigned STEP   = 4;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned LW     = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic            REQ;
  logic [LW-1:0]   TGT;
  logic            ACK;
  logic            BUSY;
  logic [LW-1:0]   LVL;
  logic [NLEG-1:0] EN;

  gf180mcu_fd_sc_mcu7t5v0__buf_leg_seq #(
    .NLEG       (NLEG),
    .STEP_CYC   (STEP),
    .SETTLE_CYC (SETTLE)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .REQ  (REQ),
    .TGT  (TGT),
    .ACK  (ACK),
    .BUSY (BUSY),
    .LVL  (LVL),
    .EN   (EN)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  int n     = 0;

  // Model: a request is a linear ramp from m_from to m_to starting at edge m_acc.
  int              m_lvl      = 0;
  bit              m_busy     = 1'b0;
  int              m_acc      = 0;
  int              m_from     = 0;
  int              m_to       = 0;
  int              m_ack_edge = -1;
  logic [NLEG-1:0] prev_en    = '0;
  bit              prev_rst   = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  // Check outputs after edge n, then drive inputs for edge n+1.
  task automatic step(input bit rq, input int tg, input bit rs);
    int d;
    int dt;
    int steps;
    int e_lvl;
    int t;
    bit e_busy;
    bit e_ack;
    e_lvl  = m_lvl;
    e_busy = 1'b0;
    if (m_busy) begin
      d     = (m_to > m_from) ? m_to - m_from : m_from - m_to;
      dt    = n - m_acc;
      steps = (dt / STEP < d) ? dt / STEP : d;
      e_lvl = (m_to > m_from) ? m_from + steps : m_from - steps;
      if (dt >= d * STEP + SETTLE) begin
        m_busy = 1'b0;
        m_lvl  = m_to;
      end else begin
        e_busy = 1'b1;
      end
    end
    e_ack = (n == m_ack_edge);
    chk("LVL", 32'(LVL), 32'(e_lvl));
    chk("EN", 32'(EN), (32'd1 << e_lvl) - 32'd1);
    chk("BUSY", 32'(BUSY), 32'(e_busy));
    chk("ACK", 32'(ACK), 32'(e_ack));
    if (!prev_rst) chk("EN_one_bit_step", 32'($countones(EN ^ prev_en) <= 1), 32'd1);
    prev_en  = EN;
    prev_rst = rs;

    RST = rs;
    REQ = rq;
    TGT = LW'(tg);
    if (rs) begin
      m_busy     = 1'b0;
      m_lvl      = 0;
      m_ack_edge = -1;
    end else if (rq && !e_busy) begin
      t = (tg > int'(NLEG)) ? int'(NLEG) : tg;
      if (t == m_lvl) begin
        m_ack_edge = n + 1;
      end else begin
        d          = (t > m_lvl) ? t - m_lvl : m_lvl - t;
        m_busy     = 1'b1;
        m_acc      = n + 1;
        m_from     = m_lvl;
        m_to       = t;
        m_ack_edge = n + 1 + d * STEP + SETTLE;
      end
    end
    @(posedge CLK);
    n++;
    @(negedge CLK);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, int'($urandom_range(0, 15)), 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    REQ = 1'b0;
    TGT = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    step(1'b0, 0, 1'b1);

    // Ramp up 0 -> 3
    step(1'b1, 3, 1'b0);
    idle(16);
    // Ramp down 5 -> 1
    step(1'b1, 5, 1'b0);
    idle(12);
    step(1'b1, 1, 1'b0);
    idle(20);
    // Saturating request, then no-op at full drive
    step(1'b1, 12, 1'b0);
    idle(36);
    step(1'b1, 8, 1'b0);
    idle(3);
    // Request while busy is ignored
    step(1'b0, 0, 1'b1);
    step(1'b1, 2, 1'b0);
    idle(4);
    step(1'b1, 7, 1'b0);
    idle(8);
    // Reset mid-ramp, then a clean request
    step(1'b0, 0, 1'b1);
    step(1'b1, 3, 1'b0);
    idle(5);
    step(1'b0, 0, 1'b1);
    step(1'b1, 1, 1'b0);
    idle(8);
    // Back-to-back: REQ held through the ACK cycle
    step(1'b1, 2, 1'b0);
    repeat (16) step(1'b1, 0, 1'b0);
    idle(4);

    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)),
           ($urandom_range(0, 199) == 0));
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__buf_leg_seq.md
Name: gf180mcu_fd_sc_mcu7t5v0__buf_leg_seq

Overview:
- Sequences the enables of NLEG parallel buffer legs that together form a programmable-drive output buffer.
- Drive strength changes one leg at a time, with a fixed dwell between steps, to bound di/dt and supply droop.
- After the last step it waits a settle interval, then acknowledges completion.
- Sits between a drive-strength configuration register and the enable pins of the buffer leg array.

Parameters:
- NLEG, 8: number of buffer legs; legal range 1..32.
- STEP_CYC, 4: cycles between successive leg changes; must be >= 1.
- SETTLE_CYC, 2: cycles from the final leg change to ACK; must be >= 1.
- LW, $clog2(NLEG+1): width of level and target fields (derived; do not override).

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- REQ  input  1  request strobe; sampled on the CLK edge.
- TGT  input  LW  requested number of enabled legs; valid when REQ=1.
- ACK  output 1  one-cycle pulse when the requested level is reached and settled.
- BUSY  output 1  high while ramping or settling.
- LVL  output LW  current number of enabled legs.
- EN  output NLEG  leg enables, thermometer code: EN[i] = (i < LVL).

Behaviour:
- Interface: one clock (CLK). Reset (RST) is synchronous and active-high. All outputs are registered.
- Reset values: EN=0, LVL=0, ACK=0, BUSY=0, state=IDLE, timer=0. RST overrides all other inputs on the same edge.
- Reset mid-ramp: all legs drop on the reset edge. No ACK is issued for the aborted request.
- States: IDLE, RAMP, SETTLE.
- IDLE:
  - REQ=1 at an edge accepts the request and captures tgt_q = min(TGT, NLEG). Values of TGT above NLEG saturate.
  - If tgt_q == LVL: ACK=1 for the next cycle, BUSY stays 0, state stays IDLE.
  - Otherwise: state=RAMP, BUSY=1, timer=STEP_CYC-1. Direction is up if tgt_q > LVL, else down.
- RAMP, at each edge:
  - If timer != 0: timer decrements.
  - If timer == 0: LVL increments or decrements by exactly 1 and EN is updated in the same edge. Ramping up sets the lowest cleared bit; ramping down clears the highest set bit.
  - If the new LVL == tgt_q: state=SETTLE, timer=SETTLE_CYC-1. Otherwise timer reloads to STEP_CYC-1.
- Step timing: the first leg change lands STEP_CYC edges after acceptance. A change of k legs completes k*STEP_CYC edges after acceptance.
- SETTLE, at each edge:
  - If timer != 0: timer decrements.
  - If timer == 0: state=IDLE, BUSY=0, ACK=1. ACK lasts exactly one cycle.
- REQ while BUSY=1 is ignored: no queue and no retargeting. TGT is don't-care when REQ=0.
- REQ in the same cycle that ACK is high is accepted, because the state is IDLE.
- EN never changes by more than one bit per edge, except on reset.
- LVL never exceeds NLEG.

Decomposition:
- Package gf180mcu_fd_sc_mcu7t5v0__buf_leg_seq_pkg holds:
  - the state enum (IDLE, RAMP, SETTLE), 2 bits;
  - function therm(lvl, n), returning the thermometer code;
  - function sat_tgt, the target clamp.
- Sub-module gf180mcu_fd_sc_mcu7t5v0__buf_leg_seq_tmr: a loadable down-counter with load value, load strobe and a zero flag. It is shared by the STEP and SETTLE intervals. Width is $clog2(max(STEP_CYC, SETTLE_CYC)+1).

Test Plan (NLEG=8, STEP_CYC=4, SETTLE_CYC=2 unless stated; e0 = acceptance edge):
- Ramp up: from reset, REQ with TGT=3 at e0.
  - BUSY=1 after e0.
  - LVL=1,2,3 at e4, e8, e12; EN=0x07 after e12.
  - ACK high exactly one cycle after e14; BUSY=0 after e14.
- Ramp down: from LVL=5, REQ with TGT=1.
  - EN steps 0x1F -> 0x0F -> 0x07 -> 0x03 -> 0x01 at e4, e8, e12, e16.
  - ACK after e18.
- Saturation and no-op:
  - TGT=12 ramps to LVL=8, EN=0xFF, with ACK at e34.
  - A following REQ with TGT=8 gives ACK after its acceptance edge, with BUSY never asserted.
- Busy ignore: REQ with TGT=2 at e0, then REQ with TGT=7 at e5. Final LVL=2 and exactly one ACK, after e10.
- Reset mid-ramp: RST asserted at e6 while LVL=1.
  - EN=0, LVL=0, BUSY=0 after e6; no ACK.
  - A new REQ with TGT=1 after reset completes normally.
- Back-to-back: REQ with TGT=0 held high through the ACK cycle of a prior ramp to 2. The new request is accepted on that edge and ramps down with no idle gap.
